// File: rtl/room_sequencer_if.sv
// Handshake bundle between the map top level and the room sequencer.
// Player position/frame timing flow in; room selection and relocation flow out.
interface room_sequencer_if;
    logic       frameStart;
    logic [9:0] playerX;
    logic [8:0] playerY;
    logic       gateOpen;
    logic [2:0] roomIndex;
    logic [7:0] wallColor;
    logic       loadPlayer;
    logic [9:0] newPlayerX;
    logic [8:0] newPlayerY;
    logic       transitioning;

    modport master (
        output frameStart, playerX, playerY, gateOpen,
        input  roomIndex, wallColor, loadPlayer, newPlayerX, newPlayerY, transitioning
    );

    modport slave (
        input  frameStart, playerX, playerY, gateOpen,
        output roomIndex, wallColor, loadPlayer, newPlayerX, newPlayerY, transitioning
    );
endinterface

// File: rtl/room_sequencer.sv
// Room sequencer: edge-exit detection, next-room selection, player relocation, map blanking.
// Optional macro CASTLE_GATE_EN: north exit from START_ROOM is held off while gateOpen=0.
module room_sequencer #(
    parameter int NUM_ROOMS    = 6,
    parameter int START_ROOM   = 0,
    parameter int EDGE_LEFT    = 8,
    parameter int EDGE_RIGHT   = 624,
    parameter int EDGE_TOP     = 4,
    parameter int EDGE_BOTTOM  = 470,
    parameter int ENTRY_MARGIN = 24,
    parameter int BLANK_FRAMES = 2
) (
    input  logic              clk_vga,
    input  logic              rst,
    room_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {PLAY, SWAP, BLANK} state_t;

    localparam logic [3:0] NR        = 4'(NUM_ROOMS);
    localparam logic [2:0] START_IDX = 3'(START_ROOM);
    localparam logic [9:0] LEFT      = 10'(EDGE_LEFT);
    localparam logic [9:0] RIGHT     = 10'(EDGE_RIGHT);
    localparam logic [8:0] TOP       = 9'(EDGE_TOP);
    localparam logic [8:0] BOTTOM    = 9'(EDGE_BOTTOM);
    localparam logic [9:0] ENTRY_E   = 10'(EDGE_LEFT + ENTRY_MARGIN);
    localparam logic [9:0] ENTRY_W   = 10'(EDGE_RIGHT - ENTRY_MARGIN);
    localparam logic [8:0] ENTRY_N   = 9'(EDGE_BOTTOM - ENTRY_MARGIN);
    localparam logic [8:0] ENTRY_S   = 9'(EDGE_TOP + ENTRY_MARGIN);
    localparam logic [3:0] CNT_LAST  = 4'(BLANK_FRAMES - 1);

    function automatic logic [7:0] room_color(input logic [2:0] r);
        case (r)
            3'd0:    return 8'hFC;
            3'd1:    return 8'h1C;
            3'd2:    return 8'h03;
            3'd3:    return 8'hE0;
            3'd4:    return 8'hE3;
            3'd5:    return 8'h1F;
            3'd6:    return 8'h92;
            default: return 8'h6D;
        endcase
    endfunction

    // Argument is always below 2*NUM_ROOMS, so a single conditional subtract suffices.
    function automatic logic [2:0] wrap_room(input logic [3:0] v);
        logic [3:0] d;
        d = v - NR;
        return (v >= NR) ? d[2:0] : v[2:0];
    endfunction

    state_t     state;
    logic [3:0] frame_cnt;

    logic       hit_n, hit_s, hit_w, hit_e, any_exit;
    logic [2:0] next_room;
    logic [9:0] next_x;
    logic [8:0] next_y;
    logic [3:0] room_ext;

    assign room_ext = {1'b0, bus.roomIndex};

    always_comb begin
`ifdef CASTLE_GATE_EN
        hit_n = (bus.playerY <= TOP) && !((bus.roomIndex == START_IDX) && !bus.gateOpen);
`else
        hit_n = (bus.playerY <= TOP);
`endif
        hit_s    = (bus.playerY >= BOTTOM);
        hit_w    = (bus.playerX <= LEFT);
        hit_e    = (bus.playerX >= RIGHT);
        any_exit = hit_n | hit_s | hit_w | hit_e;

        next_room = bus.roomIndex;
        next_x    = bus.playerX;
        next_y    = bus.playerY;
        // Priority N > S > W > E; decrements add NUM_ROOMS first so they never go negative.
        if (hit_n) begin
            next_room = wrap_room(room_ext + 4'd1);
            next_y    = ENTRY_N;
        end else if (hit_s) begin
            next_room = wrap_room(room_ext + NR - 4'd1);
            next_y    = ENTRY_S;
        end else if (hit_w) begin
            next_room = wrap_room(room_ext + NR - 4'd2);
            next_x    = ENTRY_W;
        end else if (hit_e) begin
            next_room = wrap_room(room_ext + 4'd2);
            next_x    = ENTRY_E;
        end
    end

    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            state             <= PLAY;
            frame_cnt         <= 4'd0;
            bus.roomIndex     <= START_IDX;
            bus.wallColor     <= room_color(START_IDX);
            bus.loadPlayer    <= 1'b0;
            bus.newPlayerX    <= 10'd0;
            bus.newPlayerY    <= 9'd0;
            bus.transitioning <= 1'b0;
        end else begin
            case (state)
                PLAY: begin
                    if (bus.frameStart && any_exit) begin
                        state             <= SWAP;
                        bus.roomIndex     <= next_room;
                        bus.wallColor     <= room_color(next_room);
                        bus.loadPlayer    <= 1'b1;
                        bus.newPlayerX    <= next_x;
                        bus.newPlayerY    <= next_y;
                        bus.transitioning <= 1'b1;
                    end
                end
                SWAP: begin
                    // A frameStart landing here does not count toward the blank period.
                    state          <= BLANK;
                    bus.loadPlayer <= 1'b0;
                end
                BLANK: begin
                    if (bus.frameStart) begin
                        if (frame_cnt == CNT_LAST) begin
                            frame_cnt         <= 4'd0;
                            state             <= PLAY;
                            bus.transitioning <= 1'b0;
                        end else begin
                            frame_cnt <= frame_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    state             <= PLAY;
                    bus.loadPlayer    <= 1'b0;
                    bus.transitioning <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_room_sequencer.sv
// Scoreboard bench for room_sequencer: expected swaps queued at stimulus, checked on loadPlayer.
module tb_room_sequencer;

    typedef struct {
        logic [2:0] room;
        logic [7:0] color;
        logic [9:0] x;
        logic [8:0] y;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t q[$];

    room_sequencer_if bus();

    room_sequencer dut (
        .clk_vga (clk),
        .rst     (rst),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_color(input int r);
        logic [7:0] tbl [8];
        tbl = '{8'hFC, 8'h1C, 8'h03, 8'hE0, 8'hE3, 8'h1F, 8'h92, 8'h6D};
        return tbl[r];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Every loadPlayer strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && bus.loadPlayer) begin
            if (q.size() == 0) begin
                chk("unexpected_load", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("swap_room",  32'(bus.roomIndex),  32'(e.room));
                chk("swap_color", 32'(bus.wallColor),  32'(e.color));
                chk("swap_newx",  32'(bus.newPlayerX), 32'(e.x));
                chk("swap_newy",  32'(bus.newPlayerY), 32'(e.y));
            end
        end
    end

    task automatic pulse_frame();
        @(negedge clk); bus.frameStart = 1'b1;
        @(negedge clk); bus.frameStart = 1'b0;
    endtask

    task automatic push_exp(input int room, input int nx, input int ny);
        exp_t e;
        e.room  = 3'(room);
        e.color = ref_color(room);
        e.x     = 10'(nx);
        e.y     = 9'(ny);
        q.push_back(e);
    endtask

    // Drive one exit, then walk through the blank period; hold keeps frameStart high into SWAP.
    task automatic do_exit(input int x, input int y, input int room, input int nx, input int ny,
                           input bit hold);
        push_exp(room, nx, ny);
        @(negedge clk);
        bus.playerX = 10'(x); bus.playerY = 9'(y); bus.frameStart = 1'b1;
        @(negedge clk);
        bus.playerX = 10'd320; bus.playerY = 9'd240;
        if (!hold) bus.frameStart = 1'b0;
        chk("swap_trans", 32'(bus.transitioning), 32'd1);
        if (hold) begin
            @(negedge clk); bus.frameStart = 1'b0;
            chk("hold_load_low", 32'(bus.loadPlayer), 32'd0);
        end
        pulse_frame();
        chk("blank1_trans", 32'(bus.transitioning), 32'd1);
        pulse_frame();
        chk("blank_end_trans", 32'(bus.transitioning), 32'd0);
        chk("room_after", 32'(bus.roomIndex), 32'(room));
        chk("color_after", 32'(bus.wallColor), 32'(ref_color(room)));
        chk("load_seen", 32'(q.size()), 32'd0);
    endtask

    initial begin
        bus.frameStart = 1'b0;
        bus.playerX    = 10'd320;
        bus.playerY    = 9'd240;
`ifdef CASTLE_GATE_EN
        bus.gateOpen   = 1'b1;
`else
        bus.gateOpen   = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_room",  32'(bus.roomIndex),     32'd0);
        chk("rst_color", 32'(bus.wallColor),     32'hFC);
        chk("rst_trans", 32'(bus.transitioning), 32'd0);
        chk("rst_load",  32'(bus.loadPlayer),    32'd0);
        chk("rst_newx",  32'(bus.newPlayerX),    32'd0);
        chk("rst_newy",  32'(bus.newPlayerY),    32'd0);
        rst = 1'b0;

        for (int i = 0; i < 3; i++) pulse_frame();
        chk("idle_room",  32'(bus.roomIndex),     32'd0);
        chk("idle_trans", 32'(bus.transitioning), 32'd0);

        // Just inside every edge: no exit.
        @(negedge clk);
        bus.playerX = 10'd9; bus.playerY = 9'd5; bus.frameStart = 1'b1;
        @(negedge clk); bus.frameStart = 1'b0;
        chk("inside_load", 32'(bus.loadPlayer), 32'd0);
        @(negedge clk);
        bus.playerX = 10'd623; bus.playerY = 9'd469; bus.frameStart = 1'b1;
        @(negedge clk); bus.frameStart = 1'b0;
        chk("inside_load2", 32'(bus.loadPlayer), 32'd0);
        chk("inside_room", 32'(bus.roomIndex), 32'd0);

        // Exit near the edge without frameStart: must not swap.
        bus.playerY = 9'd2;
        repeat (3) @(negedge clk);
        chk("no_frame_room", 32'(bus.roomIndex), 32'd0);
        bus.playerY = 9'd240;

`ifdef CASTLE_GATE_EN
        bus.gateOpen = 1'b0;
        @(negedge clk);
        bus.playerY = 9'd2; bus.frameStart = 1'b1;
        @(negedge clk); bus.frameStart = 1'b0; bus.playerY = 9'd240;
        chk("gate_closed_load", 32'(bus.loadPlayer), 32'd0);
        chk("gate_closed_room", 32'(bus.roomIndex), 32'd0);
        bus.gateOpen = 1'b1;
`endif

        do_exit(320, 2,   1, 320, 446, 1'b0);  // N from 0
        do_exit(320, 475, 0, 320, 28,  1'b0);  // S from 1
        do_exit(630, 240, 2, 32,  240, 1'b0);  // E from 0
        do_exit(8,   240, 0, 600, 240, 1'b1);  // W at exact edge, frameStart held into SWAP
        do_exit(4,   475, 5, 4,   28,  1'b0);  // S beats W, wraps down
        do_exit(320, 4,   0, 320, 446, 1'b0);  // N at exact edge, wraps up
        do_exit(4,   2,   1, 4,   446, 1'b0);  // N beats W
        do_exit(8,   200, 5, 600, 200, 1'b0);  // W wraps 1 -> 5
        do_exit(624, 100, 1, 32,  100, 1'b0);  // E at exact edge, 5+2 wraps to 1
        do_exit(630, 470, 0, 630, 28,  1'b0);  // S at exact edge beats E
        do_exit(630, 240, 2, 32,  240, 1'b0);
        do_exit(630, 240, 4, 32,  240, 1'b0);
        do_exit(4,   240, 2, 600, 240, 1'b0);
        do_exit(320, 2,   3, 320, 446, 1'b0);  // now in room 3

        // Reset during BLANK in room 3 (after swapping 3 -> 5).
        push_exp(5, 32, 240);
        @(negedge clk);
        bus.playerX = 10'd630; bus.frameStart = 1'b1;
        @(negedge clk); bus.frameStart = 1'b0; bus.playerX = 10'd320;
        pulse_frame();
        chk("pre_rst_trans", 32'(bus.transitioning), 32'd1);
        @(negedge clk); rst = 1'b1;
        #1;
        chk("midrst_room",  32'(bus.roomIndex),     32'd0);
        chk("midrst_color", 32'(bus.wallColor),     32'hFC);
        chk("midrst_trans", 32'(bus.transitioning), 32'd0);
        chk("midrst_load",  32'(bus.loadPlayer),    32'd0);
        chk("midrst_q",     32'(q.size()),          32'd0);
        @(negedge clk); rst = 1'b0;
        pulse_frame();
        chk("post_rst_trans", 32'(bus.transitioning), 32'd0);
        do_exit(320, 2, 1, 320, 446, 1'b0);

        repeat (4) @(negedge clk);
        chk("final_q", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
